// File: rtl/shape_selector.sv
// Debounced up/down mode selector that renders a border, a mode-dependent
// centre shape and a ring into an RGB565 pixel stream.
module shape_selector #(
    parameter int WIDTH          = 96,
    parameter int HEIGHT         = 64,
    parameter int BORDER         = 7,
    parameter int NUM_MODES      = 7,
    parameter int DEBOUNCE_TICKS = 200,
    parameter int SHAPE_R        = 8,
    parameter int RING_RIN       = 10,
    parameter int RING_ROUT      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [12:0] pixel_index,
    output logic [2:0]  mode,
    output logic        mode_changed,
    output logic [15:0] pixel_color
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [2:0]    MODE_LAST = 3'(NUM_MODES - 1);

    logic [1:0]         btn_raw;
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         stable_q, stable_d, press_q, press_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               mode_changed_q, mode_changed_d;
    logic [15:0]        pixel_color_q, pixel_color_d;

    assign btn_raw = {btn_down, btn_up};

    // Bit 0 is the up button, bit 1 the down button; press fires only on a 0->1 acceptance.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = '0;
        cnt_d    = cnt_q;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press_d[i]  = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mode_d         = mode_q;
        mode_changed_d = 1'b0;
        if (press_q[0] && !press_q[1]) begin
            mode_d         = (mode_q == MODE_LAST) ? 3'd0 : mode_q + 3'd1;
            mode_changed_d = 1'b1;
        end else if (press_q[1] && !press_q[0]) begin
            mode_d         = (mode_q == 3'd0) ? MODE_LAST : mode_q - 3'd1;
            mode_changed_d = 1'b1;
        end
    end

    int          px, x, y, dx, dy, d2, adx, ady, m;
    logic        shape_hit;
    logic [15:0] shape_color, ring_color;

    always_comb begin
        px  = int'({19'd0, pixel_index});
        x   = px % WIDTH;
        y   = px / WIDTH;
        dx  = x - WIDTH / 2;
        dy  = y - HEIGHT / 2;
        d2  = dx * dx + dy * dy;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        m   = int'({29'd0, mode_q});

        shape_hit = 1'b0;
        if (m >= 1 && m <= 6) begin
            if (m <= 3) shape_hit = (d2 <= SHAPE_R * SHAPE_R);
            else        shape_hit = (adx <= SHAPE_R) && (ady <= SHAPE_R);
        end

        case ((m - 1) % 3)
            0:       shape_color = 16'h07E0;
            1:       shape_color = 16'hFC00;
            default: shape_color = 16'hF800;
        endcase
        ring_color = (m <= 3 || m == 7) ? 16'hFC00 : 16'hFFFF;

        if (px >= WIDTH * HEIGHT)
            pixel_color_d = 16'h0000;
        else if (x < BORDER || x >= WIDTH - BORDER || y < BORDER || y >= HEIGHT - BORDER)
            pixel_color_d = 16'hF800;
        else if (shape_hit)
            pixel_color_d = shape_color;
        else if (d2 >= RING_RIN * RING_RIN && d2 <= RING_ROUT * RING_ROUT)
            pixel_color_d = ring_color;
        else
            pixel_color_d = 16'h0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            stable_q       <= '0;
            press_q        <= '0;
            cnt_q          <= '0;
            mode_q         <= '0;
            mode_changed_q <= 1'b0;
            pixel_color_q  <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            press_q        <= press_d;
            cnt_q          <= cnt_d;
            mode_q         <= mode_d;
            mode_changed_q <= mode_changed_d;
            pixel_color_q  <= pixel_color_d;
        end
    end

    assign mode         = mode_q;
    assign mode_changed = mode_changed_q;
    assign pixel_color  = pixel_color_q;

endmodule

// File: tb/tb_shape_selector.sv
// Scoreboard bench for shape_selector: expected modes and pixel colours are
// queued when stimulus is applied and checked when the DUT produces them.
module tb_shape_selector;

    logic        clk, rst, tick, btn_up, btn_down;
    logic [12:0] pixel_index;
    logic [2:0]  mode;
    logic        mode_changed;
    logic [15:0] pixel_color;

    int          tests_run  = 0;
    int          fail_count = 0;
    int          tick_div;
    logic [2:0]  exp_mode;
    logic [2:0]  prev_mode;
    logic [2:0]  mon_exp;
    logic        mon_en;
    logic [2:0]  mode_sb [$];
    logic [15:0] pix_sb [$];

    shape_selector #(.DEBOUNCE_TICKS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .pixel_index  (pixel_index),
        .mode         (mode),
        .mode_changed (mode_changed),
        .pixel_color  (pixel_color)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick     = 1'b0;
        tick_div = 0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % 4;
            tick     = (tick_div == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Independent reference for the default 96x64 geometry.
    function automatic logic [15:0] ref_color(input int md, input int idx);
        int x, y, dx, dy, d2;
        logic hit;
        x  = idx % 96;
        y  = idx / 96;
        dx = x - 48;
        dy = y - 32;
        d2 = dx * dx + dy * dy;
        if (idx >= 6144) return 16'h0000;
        if (x < 7 || x > 88 || y < 7 || y > 56) return 16'hF800;
        hit = 1'b0;
        if (md >= 1 && md <= 3) hit = (d2 <= 64);
        if (md >= 4 && md <= 6) hit = (dx >= -8 && dx <= 8 && dy >= -8 && dy <= 8);
        if (hit) begin
            if (md == 1 || md == 4) return 16'h07E0;
            if (md == 2 || md == 5) return 16'hFC00;
            return 16'hF800;
        end
        if (d2 >= 100 && d2 <= 144) return (md <= 3 || md == 7) ? 16'hFC00 : 16'hFFFF;
        return 16'h0000;
    endfunction

    task automatic applyStimulus(input string tag, input int idx, input logic [15:0] expected);
        @(negedge clk);
        pixel_index = 13'(idx);
        pix_sb.push_back(expected);
        @(negedge clk);
        checkOutput(tag, 32'(pixel_color), 32'(pix_sb.pop_front()));
    endtask

    task automatic sweep_pixels(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = (i % 4 == 3) ? int'($urandom_range(0, 8191)) : int'($urandom_range(2200, 4000));
            applyStimulus("pixel_sweep", idx, ref_color(int'(exp_mode), idx));
        end
    endtask

    task automatic hold_buttons(input logic up, input logic dn, input int cycles);
        @(negedge clk);
        btn_up   = up;
        btn_down = dn;
        repeat (cycles) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic press_up();
        exp_mode = (exp_mode == 3'd6) ? 3'd0 : exp_mode + 3'd1;
        mode_sb.push_back(exp_mode);
        hold_buttons(1'b1, 1'b0, 24);
    endtask

    task automatic press_down();
        exp_mode = (exp_mode == 3'd0) ? 3'd6 : exp_mode - 3'd1;
        mode_sb.push_back(exp_mode);
        hold_buttons(1'b0, 1'b1, 24);
    endtask

    // Every mode_changed pulse must carry the next queued mode; any silent mode move is an error.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mode_changed) begin
                if (mode_sb.size() == 0) begin
                    checkOutput("unexpected_mode_changed", 32'(mode), 32'(prev_mode));
                end else begin
                    mon_exp = mode_sb.pop_front();
                    checkOutput("mode_after_change", 32'(mode), 32'(mon_exp));
                end
            end else if (mode != prev_mode) begin
                checkOutput("mode_moved_without_pulse", 32'(mode), 32'(prev_mode));
            end
        end
        prev_mode = mode;
    end

    initial begin
        rst         = 1'b1;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        pixel_index = 13'(32 * 96 + 48);
        exp_mode    = 3'd0;
        mon_en      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mode", 32'(mode), 32'd0);
        checkOutput("reset_mode_changed", 32'(mode_changed), 32'd0);
        checkOutput("reset_pixel_color", 32'(pixel_color), 32'd0);

        @(negedge clk);
        rst         = 1'b0;
        pixel_index = 13'd0;
        pix_sb.push_back(16'hF800);
        @(negedge clk);
        checkOutput("first_pixel_after_reset", 32'(pixel_color), 32'(pix_sb.pop_front()));
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        press_up();
        checkOutput("up_press_mode", 32'(mode), 32'd1);
        applyStimulus("m1_centre", 32 * 96 + 48, 16'h07E0);
        applyStimulus("m1_ring", 32 * 96 + 59, 16'hFC00);
        applyStimulus("m1_border", 0, 16'hF800);
        applyStimulus("m1_out_of_range", 6144, 16'h0000);
        applyStimulus("m1_corner_not_circle", 40 * 96 + 56, 16'hFC00);
        sweep_pixels(6);

        press_down();
        hold_buttons(1'b1, 1'b0, 8);
        checkOutput("glitch_mode", 32'(mode), 32'd0);

        press_down();
        checkOutput("down_wrap_mode", 32'(mode), 32'd6);
        sweep_pixels(4);
        for (int i = 0; i < 7; i++) begin
            press_up();
            sweep_pixels(4);
        end
        checkOutput("up_wrap_mode", 32'(mode), 32'd6);

        hold_buttons(1'b1, 1'b1, 24);
        checkOutput("both_buttons_mode", 32'(mode), 32'd6);

        press_down();
        applyStimulus("m5_ring_white", 32 * 96 + 59, 16'hFFFF);
        press_down();
        applyStimulus("m4_square_corner", 40 * 96 + 56, 16'h07E0);
        sweep_pixels(6);

        mon_en = 1'b0;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_mode", 32'(mode), 32'd0);
        checkOutput("mid_reset_mode_changed", 32'(mode_changed), 32'd0);
        checkOutput("mid_reset_pixel_color", 32'(pixel_color), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        exp_mode = 3'd0;
        repeat (6) @(negedge clk);
        checkOutput("held_through_reset_early", 32'(mode), 32'd0);
        exp_mode = 3'd1;
        mode_sb.push_back(exp_mode);
        mon_en = 1'b1;
        repeat (24) @(negedge clk);
        btn_up = 1'b0;
        repeat (24) @(negedge clk);
        checkOutput("held_through_reset_mode", 32'(mode), 32'd1);
        applyStimulus("post_reset_centre", 32 * 96 + 48, ref_color(int'(exp_mode), 32 * 96 + 48));

        repeat (10) @(negedge clk);
        checkOutput("mode_queue_drained", 32'(mode_sb.size()), 32'd0);
        checkOutput("final_mode", 32'(mode), 32'(exp_mode));

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/shape_selector.md
SHAPE_SELECTOR -- requirements
Module: shape_selector

Interface
REQ-001 Parameter WIDTH, default 96: display columns.
REQ-002 Parameter HEIGHT, default 64: display rows.
REQ-003 Parameter BORDER, default 7: border thickness in pixels.
REQ-004 Parameter NUM_MODES, default 7, legal range 2..8: number of selectable modes.
REQ-005 Parameter DEBOUNCE_TICKS, default 200, minimum 1: ticks a raw level must hold before it is accepted.
REQ-006 Parameters SHAPE_R=8, RING_RIN=10, RING_ROUT=12: centre-shape half-size, ring inner radius and ring outer radius, in pixels.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 tick  in  1  one-clk-wide debounce timebase strobe (nominally 1 kHz).
REQ-010 btn_up  in  1  raw, asynchronous pushbutton that increments the mode.
REQ-011 btn_down  in  1  raw, asynchronous pushbutton that decrements the mode.
REQ-012 pixel_index  in  13  raster address, y*WIDTH+x.
REQ-013 mode  out  3  current mode, registered.
REQ-014 mode_changed  out  1  one-clk pulse in the cycle after mode updates.
REQ-015 pixel_color  out  16  RGB565 pixel for the previous cycle's pixel_index.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser before debounce.
REQ-017 Debounce, per button, evaluated only on cycles with tick=1:
- synchronised level equals the stable value: clear the counter;
- synchronised level differs from the stable value: increment the counter;
- counter reaches DEBOUNCE_TICKS-1 while the level still differs: stable takes the level and the counter clears.
REQ-018 A 0->1 transition of a stable value SHALL produce a press event one clk wide; 1->0 transitions produce no event.
REQ-019 On an up event, mode SHALL become mode+1, wrapping from NUM_MODES-1 to 0.
REQ-020 On a down event, mode SHALL become mode-1, wrapping from 0 to NUM_MODES-1.
REQ-021 Up and down events in the same clk SHALL leave mode unchanged and SHALL NOT assert mode_changed.
REQ-022 mode_changed SHALL assert exactly one clk after each mode register update, and at no other time.
REQ-023 Pixel decode: x = pixel_index mod WIDTH, y = pixel_index div WIDTH, dx = x-WIDTH/2, dy = y-HEIGHT/2, all signed; d2 = dx*dx+dy*dy, computed at least 13 bits wide with no truncation.
REQ-024 Colour priority, highest first:
- pixel_index >= WIDTH*HEIGHT -> 16'h0000;
- border region (x<BORDER, x>=WIDTH-BORDER, y<BORDER or y>=HEIGHT-BORDER) -> 16'hF800;
- centre shape hit -> shape colour;
- ring hit, RING_RIN^2 <= d2 <= RING_ROUT^2 -> ring colour;
- otherwise -> 16'h0000.
REQ-025 Centre shape by mode:
- mode 0 and mode >= 7: no shape;
- mode m in 1..6: shape = circle (d2 <= SHAPE_R^2) when m <= 3, square (|dx| <= SHAPE_R and |dy| <= SHAPE_R) when m >= 4;
- colour index (m-1) mod 3 selects green 16'h07E0, orange 16'hFC00, red 16'hF800.
REQ-026 Ring colour SHALL be orange 16'hFC00 when mode <= 3 or mode == 7, else white 16'hFFFF.
REQ-027 pixel_color SHALL be registered with latency exactly 1 clk from pixel_index, using the mode value present in the same cycle as pixel_index.
REQ-028 A mode change SHALL take effect on the first pixel_index sampled after the mode register updates; no frame alignment is applied.

Reset
REQ-029 While rst=1, the following SHALL all be 0: mode, mode_changed, pixel_color, synchroniser flops, stable values, debounce counters and press events.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; a button held through reset release SHALL require a full debounce and SHALL register as a press.
REQ-031 After rst deasserts, the first pixel_color update SHALL occur on the first rising clk edge.

Verification
REQ-032 DEBOUNCE_TICKS=4, tick every 4 clk; btn_up held for 4 ticks -> mode 0->1, one mode_changed pulse.
REQ-033 btn_up glitches high for 2 ticks, then low -> mode stays 0, no mode_changed.
REQ-034 From mode 0, one debounced btn_down press -> mode=6; 7 debounced up presses -> mode back at 6 (wrap).
REQ-035 Both buttons pressed, debounce windows aligned to the same tick -> mode unchanged, no mode_changed.
REQ-036 mode=1, pixel_index=32*96+48 -> next cycle 16'h07E0; pixel 32*96+59 -> 16'hFC00; pixel 0 -> 16'hF800; pixel 6144 -> 16'h0000.
REQ-037 mode=4, pixel (x=56, y=40) -> 16'h07E0 (square corner); mode=1, same pixel -> not 16'h07E0; mode=5 ring pixel (x=59, y=32) -> 16'hFFFF.
